lane_car_ctrl: RTL and testbench



---
 rtl/lane_car_ctrl.sv | 149 ++++++++++++++
 tb/tb_lane_car_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/lane_car_ctrl.sv
// Player-car lane controller: edge-detected left/right presses slide the car
// between lanes, with a one-deep pending move and a timed crash freeze.
module lane_car_ctrl #(
  parameter int NUM_LANES   = 3,
  parameter int LANE0_X     = 197,
  parameter int LANE_PITCH  = 82,
  parameter int CAR_Y       = 357,
  parameter int SLIDE_STEP  = 41,
  parameter int CRASH_TICKS = 16
) (
  input  logic       logic_clk,
  input  logic       reset,
  input  logic       left,
  input  logic       right,
  input  logic       collision,
  output logic [9:0] car_x,
  output logic [9:0] car_y,
  output logic [2:0] lane,
  output logic       moving,
  output logic       crashed
);

  typedef enum logic [1:0] {IDLE, SLIDE, CRASH} state_t;

  localparam int             CW        = (CRASH_TICKS > 1) ? $clog2(CRASH_TICKS) : 1;
  localparam logic [CW-1:0]  CNT_INIT  = CW'(CRASH_TICKS - 1);
  localparam logic [2:0]     LAST_LANE = 3'(NUM_LANES - 1);
  localparam logic [2:0]     HOME_LANE = 3'(NUM_LANES / 2);
  localparam logic [9:0]     STEP      = 10'(SLIDE_STEP);

  function automatic logic [9:0] laneX(input logic [2:0] n);
    laneX = 10'(LANE0_X + int'(n) * LANE_PITCH);
  endfunction

  state_t        r_state, w_state;
  logic [2:0]    r_lane, w_lane;
  logic [2:0]    r_target, w_target;
  logic [9:0]    r_carX, w_carX;
  logic          r_pendValid, w_pendValid;
  logic          r_pendRight, w_pendRight;
  logic [CW-1:0] r_cnt, w_cnt;
  logic          r_leftPrev, r_rightPrev;

  logic          w_lp, w_rp, w_press;
  logic          w_chainValid, w_chainRight;
  logic [9:0]    w_stepX;

  always_ff @(posedge logic_clk) begin
    r_leftPrev  <= left;
    r_rightPrev <= right;
    if (reset) begin
      r_state     <= IDLE;
      r_lane      <= HOME_LANE;
      r_target    <= HOME_LANE;
      r_carX      <= laneX(HOME_LANE);
      r_pendValid <= 1'b0;
      r_pendRight <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state;
      r_lane      <= w_lane;
      r_target    <= w_target;
      r_carX      <= w_carX;
      r_pendValid <= w_pendValid;
      r_pendRight <= w_pendRight;
      r_cnt       <= w_cnt;
    end
  end

  // Simultaneous left and right rises cancel each other out.
  always_comb begin
    w_lp         = left & ~r_leftPrev & ~(right & ~r_rightPrev);
    w_rp         = right & ~r_rightPrev & ~(left & ~r_leftPrev);
    w_press      = w_lp | w_rp;
    w_chainValid = w_press | r_pendValid;
    w_chainRight = w_press ? w_rp : r_pendRight;
    w_stepX      = (r_target > r_lane) ? (r_carX + STEP) : (r_carX - STEP);

    w_state     = r_state;
    w_lane      = r_lane;
    w_target    = r_target;
    w_carX      = r_carX;
    w_pendValid = r_pendValid;
    w_pendRight = r_pendRight;
    w_cnt       = r_cnt;

    case (r_state)
      IDLE: begin
        if (collision) begin
          w_state     = CRASH;
          w_cnt       = CNT_INIT;
          w_pendValid = 1'b0;
        end else if (w_lp && r_lane != 3'd0) begin
          w_state  = SLIDE;
          w_target = r_lane - 3'd1;
          w_carX   = r_carX - STEP;
        end else if (w_rp && r_lane != LAST_LANE) begin
          w_state  = SLIDE;
          w_target = r_lane + 3'd1;
          w_carX   = r_carX + STEP;
        end
      end

      SLIDE: begin
        if (collision) begin
          w_state     = CRASH;
          w_cnt       = CNT_INIT;
          w_pendValid = 1'b0;
        end else begin
          w_carX = w_stepX;
          // On arrival a press seen this same edge takes precedence over the stored one.
          if (w_stepX == laneX(r_target)) begin
            w_lane      = r_target;
            w_pendValid = 1'b0;
            if (w_chainValid && w_chainRight && r_target != LAST_LANE) begin
              w_target = r_target + 3'd1;
            end else if (w_chainValid && !w_chainRight && r_target != 3'd0) begin
              w_target = r_target - 3'd1;
            end else begin
              w_state = IDLE;
            end
          end else if (w_press) begin
            w_pendValid = 1'b1;
            w_pendRight = w_rp;
          end
        end
      end

      CRASH: begin
        if (r_cnt == '0) begin
          w_state  = IDLE;
          w_carX   = laneX(r_lane);
          w_target = r_lane;
        end else begin
          w_cnt = r_cnt - 1'b1;
        end
      end

      default: w_state = IDLE;
    endcase
  end

  assign car_x   = r_carX;
  assign car_y   = 10'(CAR_Y);
  assign lane    = r_lane;
  assign moving  = (r_state == SLIDE);
  assign crashed = (r_state == CRASH);

endmodule

// File: tb/tb_lane_car_ctrl.sv
// Directed bench for lane_car_ctrl: default geometry, SLIDE_STEP=1 timing, and
// a 5-lane reset check, all run side by side on one clock.
module tb_lane_car_ctrl;

  logic logic_clk = 1'b0;
  always #5 logic_clk = ~logic_clk;

  logic       aReset, aLeft, aRight, aColl;
  logic [9:0] aCarX, aCarY;
  logic [2:0] aLane;
  logic       aMoving, aCrashed;

  logic       bReset, bLeft, bRight, bColl;
  logic [9:0] bCarX, bCarY;
  logic [2:0] bLane;
  logic       bMoving, bCrashed;

  logic       cLeft, cRight, cColl;
  logic [9:0] cCarX, cCarY;
  logic [2:0] cLane;
  logic       cMoving, cCrashed;

  int checks = 0;
  int errors = 0;
  int edgeNum = 0;

  lane_car_ctrl dutA (
    .logic_clk(logic_clk), .reset(aReset), .left(aLeft), .right(aRight),
    .collision(aColl), .car_x(aCarX), .car_y(aCarY), .lane(aLane),
    .moving(aMoving), .crashed(aCrashed)
  );

  lane_car_ctrl #(.SLIDE_STEP(1)) dutB (
    .logic_clk(logic_clk), .reset(bReset), .left(bLeft), .right(bRight),
    .collision(bColl), .car_x(bCarX), .car_y(bCarY), .lane(bLane),
    .moving(bMoving), .crashed(bCrashed)
  );

  lane_car_ctrl #(.NUM_LANES(5)) dutC (
    .logic_clk(logic_clk), .reset(aReset), .left(cLeft), .right(cRight),
    .collision(cColl), .car_x(cCarX), .car_y(cCarY), .lane(cLane),
    .moving(cMoving), .crashed(cCrashed)
  );

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge logic_clk);
      #1;
      edgeNum++;
    end
  endtask

  task automatic runTo(input int target);
    while (edgeNum < target) applyStimulus(1);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkA(input string tag, input int x, input int ln, input int mv, input int cr);
    checkOutput({tag, ".car_x"},   32'(aCarX),    32'(x));
    checkOutput({tag, ".lane"},    32'(aLane),    32'(ln));
    checkOutput({tag, ".moving"},  32'(aMoving),  32'(mv));
    checkOutput({tag, ".crashed"}, 32'(aCrashed), 32'(cr));
  endtask

  task automatic checkB(input string tag, input int x, input int ln, input int mv, input int cr);
    checkOutput({tag, ".car_x"},   32'(bCarX),    32'(x));
    checkOutput({tag, ".lane"},    32'(bLane),    32'(ln));
    checkOutput({tag, ".moving"},  32'(bMoving),  32'(mv));
    checkOutput({tag, ".crashed"}, 32'(bCrashed), 32'(cr));
  endtask

  initial begin
    aReset = 1'b1; aLeft = 1'b1; aRight = 1'b0; aColl = 1'b0;
    bReset = 1'b1; bLeft = 1'b0; bRight = 1'b0; bColl = 1'b0;
    cLeft = 1'b0;  cRight = 1'b0; cColl = 1'b0;

    // Left held through reset and afterwards must not register as a press.
    applyStimulus(2);
    aReset = 1'b0; bReset = 1'b0;
    applyStimulus(5);
    checkA("heldLeft", 279, 1, 0, 0);
    checkOutput("a.car_y", 32'(aCarY), 32'd357);
    checkOutput("c.resetLane", 32'(cLane), 32'd2);
    checkOutput("c.resetX", 32'(cCarX), 32'd361);
    checkOutput("c.car_y", 32'(cCarY), 32'd357);
    aLeft = 1'b0;
    applyStimulus(1);

    aLeft = 1'b1; aRight = 1'b1;
    applyStimulus(1);
    checkA("bothPress", 279, 1, 0, 0);
    aLeft = 1'b0; aRight = 1'b0;
    applyStimulus(1);

    aRight = 1'b1;
    applyStimulus(1);
    checkA("right.e0", 320, 1, 1, 0);
    aRight = 1'b0;
    applyStimulus(1);
    checkA("right.e1", 361, 2, 0, 0);
    aRight = 1'b1;
    applyStimulus(1);
    checkA("rightAtEdge", 361, 2, 0, 0);
    aRight = 1'b0;
    applyStimulus(1);

    aLeft = 1'b1;
    applyStimulus(1);
    checkA("midSlide", 320, 2, 1, 0);
    aLeft = 1'b0; aReset = 1'b1;
    applyStimulus(1);
    checkA("resetMidSlide", 279, 1, 0, 0);
    aReset = 1'b0;
    applyStimulus(3);
    checkA("afterReset", 279, 1, 0, 0);

    aLeft = 1'b1;
    applyStimulus(1);
    checkA("leftA.e0", 238, 1, 1, 0);
    aLeft = 1'b0;
    applyStimulus(1);
    checkA("leftA.e1", 197, 0, 0, 0);
    aLeft = 1'b1;
    applyStimulus(1);
    checkA("leftAtEdge", 197, 0, 0, 0);
    aLeft = 1'b0;
    applyStimulus(1);

    // Collision held across the whole freeze re-enters CRASH right after exit.
    aColl = 1'b1;
    applyStimulus(1);
    checkA("crashA.E", 197, 0, 0, 1);
    applyStimulus(15);
    checkA("crashA.E15", 197, 0, 0, 1);
    applyStimulus(1);
    checkA("crashA.E16", 197, 0, 0, 0);
    applyStimulus(1);
    checkA("crashA.reenter", 197, 0, 0, 1);
    aColl = 1'b0;
    applyStimulus(16);
    checkA("crashA.exit2", 197, 0, 0, 0);

    // SLIDE_STEP=1: left slide with a right press stored as pending.
    bLeft = 1'b1;
    edgeNum = -1;
    applyStimulus(1);
    checkB("slowL.e0", 278, 1, 1, 0);
    bLeft = 1'b0;
    runTo(19);
    bRight = 1'b1;
    applyStimulus(1);
    bRight = 1'b0;
    runTo(80);
    checkB("slowL.e80", 198, 1, 1, 0);
    applyStimulus(1);
    checkB("slowL.e81", 197, 0, 1, 0);
    applyStimulus(1);
    checkB("slowR.e82", 198, 0, 1, 0);
    runTo(162);
    checkB("slowR.e162", 278, 0, 1, 0);
    applyStimulus(1);
    checkB("slowR.e163", 279, 1, 0, 0);
    applyStimulus(2);

    // Crash mid-slide freezes at the source lane and restores its x on exit.
    bLeft = 1'b1;
    edgeNum = -1;
    applyStimulus(1);
    checkB("crashB.e0", 278, 1, 1, 0);
    bLeft = 1'b0;
    runTo(29);
    checkB("crashB.e29", 249, 1, 1, 0);
    bColl = 1'b1;
    applyStimulus(1);
    checkB("crashB.e30", 249, 1, 0, 1);
    bColl = 1'b0;
    runTo(31);
    bLeft = 1'b1;
    runTo(33);
    bLeft = 1'b0;
    runTo(35);
    bRight = 1'b1;
    runTo(39);
    bRight = 1'b0;
    runTo(41);
    bColl = 1'b1;
    runTo(43);
    bColl = 1'b0;
    runTo(45);
    checkB("crashB.e45", 249, 1, 0, 1);
    applyStimulus(1);
    checkB("crashB.e46", 279, 1, 0, 0);
    applyStimulus(2);
    checkB("crashB.e48", 279, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
